// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO slave with per-pin direction, synchronised inputs and edge/level interrupts.
// Define WB_GPIO_IRQ_SETCLR_EN to implement the OUT_SET/OUT_CLR registers.
module wb_gpio_irq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] RESET_DIR   = '0,
  parameter logic [31:0] RESET_OUT   = '0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);
  localparam logic [2:0] PRIME_CNT = 3'(SYNC_STAGES + 1);
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d, type_q, type_d, pol_q, pol_d;
  logic [WIDTH-1:0] edge_q, edge_d, prev_q, m, wm, sync, status, ev, din;
  logic [SYNC_STAGES*WIDTH-1:0] sh_q;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] dat_q, dat_d, rd, bmask;
  logic ack_q, irq_q, irq_d, req, wr, prime;
  logic unused_ok;
  assign req = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr = req & wb_we_i;
  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign m = bmask[WIDTH-1:0];
  assign wm = wb_dat_i[WIDTH-1:0] & m;
  assign sync = sh_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign prime = cnt_q == PRIME_CNT;
  // Edge detection is held off until the synchroniser has flushed its reset zeros
  assign ev = type_q & {WIDTH{prime}} & ((pol_q & sync & ~prev_q) | (~pol_q & ~sync & prev_q));
  assign status = (type_q & edge_q) | (~type_q & ~(sync ^ pol_q));
  assign din = (dir_q & out_q) | (~dir_q & sync);
  assign unused_ok = ^{wb_dat_i, bmask};
  always_comb begin
    dir_d = wr && wb_adr_i == 3'd1 ? (dir_q & ~m) | wm : dir_q;
    en_d = wr && wb_adr_i == 3'd2 ? (en_q & ~m) | wm : en_q;
    type_d = wr && wb_adr_i == 3'd3 ? (type_q & ~m) | wm : type_q;
    pol_d = wr && wb_adr_i == 3'd4 ? (pol_q & ~m) | wm : pol_q;
    edge_d = (edge_q & ~(wm & {WIDTH{wr && wb_adr_i == 3'd5}})) | ev;
`ifdef WB_GPIO_IRQ_SETCLR_EN
    out_d = wr && wb_adr_i == 3'd6 ? out_q | wm :
            wr && wb_adr_i == 3'd7 ? out_q & ~wm :
            wr && wb_adr_i == 3'd0 ? (out_q & ~m) | wm : out_q;
`else
    out_d = wr && wb_adr_i == 3'd0 ? (out_q & ~m) | wm : out_q;
`endif
    cnt_d = prime ? cnt_q : cnt_q + 3'd1;
    irq_d = |(status & en_q);
    case (wb_adr_i)
      3'd0: rd = 32'(din);
      3'd1: rd = 32'(dir_q);
      3'd2: rd = 32'(en_q);
      3'd3: rd = 32'(type_q);
      3'd4: rd = 32'(pol_q);
      3'd5: rd = 32'(status);
      default: rd = '0;
    endcase
    dat_d = req && !wb_we_i ? rd : '0;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      out_q <= RESET_OUT[WIDTH-1:0];
      dir_q <= RESET_DIR[WIDTH-1:0];
      en_q <= '0;
      type_q <= '0;
      pol_q <= '0;
      edge_q <= '0;
      prev_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      en_q <= en_d;
      type_q <= type_d;
      pol_q <= pol_d;
      edge_q <= edge_d;
      prev_q <= sync;
      sh_q <= {sh_q[(SYNC_STAGES-1)*WIDTH-1:0], gpio_i};
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      ack_q <= req;
      irq_q <= irq_d;
    end
  end
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign gpio_o = out_q;
  assign gpio_dir_o = dir_q;
  assign irq_o = irq_q;
endmodule
